mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Top-level controller for the Monte Carlo option-pricing datapath.
- Takes parameter words and a 2-bit command from the chip pins, and drives the configuration registers.
- Sequences the Sobol generator, path generator and pricing accumulator through N paths × M time steps, then latches the 16-bit priced result for readout.
- Sits between the pad-level interface and the three datapath blocks.

Parameters:
- CNT_W, 12, width of path/step counters and config words.
- DATA_W, 16, width of Sobol sample, result and dout (FP16).
- TIMEOUT, 1023, maximum cycles to wait on any datapath handshake before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  2  00 NOP, 01 LOAD, 10 RUN, 11 READ.
- din  in  CNT_W  parameter word, sampled when cmd==LOAD in IDLE/LOAD.
- dout  out  DATA_W  result in DONE, else {4'b0, path_cnt}.
- busy  out  1  high in REQ, WAIT_RN, PATH_END, FLUSH.
- done  out  1  high in DONE.
- err  out  1  sticky: timeout or zero count; cleared by next RUN or by reset.
- cfg_s0  out  CNT_W  spot price word (load index 0).
- cfg_strike  out  CNT_W  strike word (index 1).
- cfg_npaths  out  CNT_W  path count (index 2).
- cfg_nsteps  out  CNT_W  steps per path (index 3).
- sobol_start  out  1  one-cycle request for next sample.
- sobol_valid  in  1  sample ready, one-cycle pulse.
- sobol_data  in  DATA_W  sample, forwarded to path generator.
- pg_valid  out  1  one-cycle step strobe to path generator.
- pg_data  out  DATA_W  registered copy of sobol_data.
- pg_first  out  1  qualifies pg_valid: step 0 of a path.
- pg_last  out  1  qualifies pg_valid: final step of a path.
- pg_path_done  in  1  path generator terminal value ready.
- pr_accum  out  1  one-cycle strobe: pricing accumulates terminal value.
- pr_finish  out  1  one-cycle strobe: pricing computes discounted mean.
- pr_valid  in  1  pricing result ready.
- pr_result  in  DATA_W  priced option value.

Behaviour:
- Reset: all outputs 0, state IDLE, cfg registers 0, load index 0, counters 0, result 0.
- IDLE:
  - cmd==LOAD: write din to cfg[idx], idx++ (wraps 3→0); go to LOAD.
  - cmd==RUN: clear err, path_cnt, step_cnt. If npaths==0 or nsteps==0, set err, result=0, go to DONE. Otherwise go to REQ.
  - cmd NOP/READ: stay.
- LOAD: each cycle with cmd==LOAD writes one word and increments idx. Any other cmd returns to IDLE; idx is retained, so a 5th word overwrites cfg_s0. In IDLE, cmd==NOP resets idx to 0.
- REQ: sobol_start=1 for exactly one cycle; go to WAIT_RN; timer cleared.
- WAIT_RN:
  - On sobol_valid: the next cycle asserts pg_valid with pg_data=sobol_data, pg_first=(step_cnt==0), pg_last=(step_cnt==nsteps-1). pg_valid is a registered output, so latency from sobol_valid to pg_valid is 1 cycle.
  - If the step was the last one: step_cnt←0, go to PATH_END. Else step_cnt++, go to REQ.
  - Both pg_first and pg_last are high when nsteps==1.
- PATH_END: on pg_path_done, pr_accum=1 for one cycle and path_cnt++. If path_cnt==npaths-1, pulse pr_finish and go to FLUSH; else go to REQ.
- FLUSH: on pr_valid, latch pr_result into result; go to DONE.
- DONE: done=1; dout=result. cmd==RUN starts a new run. cmd==LOAD goes to LOAD, with din written that cycle. NOP/READ hold in DONE.
- Timeout: in WAIT_RN, PATH_END or FLUSH, the timer increments every cycle the awaited input is low. When timer==TIMEOUT: set err, result=16'h7E00 (FP16 NaN), go to DONE. The timer clears on every state entry.
- Commands other than those listed in busy states are ignored; config writes are blocked, so cfg stays stable through a run.
- Input pulses (sobol_valid, pg_path_done, pr_valid) arriving in states that do not await them are ignored.
- Asynchronous rst mid-run returns everything to reset values immediately; a partial run is discarded.
- Counters are CNT_W unsigned. nsteps-1 and npaths-1 comparisons are done only after the zero check, so no underflow is possible.

Decomposition:
- Shared package mc_pkg:
  - cmd encodings CMD_NOP/LOAD/RUN/READ.
  - state enum IDLE, LOAD, REQ, WAIT_RN, PATH_END, FLUSH, DONE.
  - cfg index constants.
  - FP16_NAN constant.
- One natural sub-module: mc_cfg_regfile (4×CNT_W load-indexed register file with idx counter).
- The FSM and counters stay in mc_sequencer.

Test Plan:
- Load 4 words (100, 105, 2, 3) with cmd=01 for 4 cycles, then NOP → cfg_s0=100, cfg_strike=105, cfg_npaths=2, cfg_nsteps=3, idx=0.
- RUN with npaths=2, nsteps=3, and a responder answering sobol_valid 2 cycles after start, pg_path_done 1 cycle after pg_last, and pr_valid=16'h4500 3 cycles after pr_finish → expect:
  - 6 sobol_start pulses and 6 pg_valid pulses.
  - pg_first on pulses 1 and 4; pg_last on pulses 3 and 6.
  - 2 pr_accum pulses and 1 pr_finish pulse.
  - done=1 and dout=16'h4500.
- nsteps=1, npaths=1: the single pg_valid has pg_first=pg_last=1 → done, no err.
- npaths=0, RUN → next cycle done=1, err=1, dout=0, no sobol_start.
- Withhold sobol_valid, TIMEOUT=8 → after 8 wait cycles err=1, done=1, dout=16'h7E00. A following RUN clears err.
- Assert rst mid WAIT_RN → all outputs 0 and state IDLE immediately. Spurious sobol_valid while in IDLE → no pg_valid.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the Monte Carlo sequencer: pin commands, FSM states and config slots.
package mc_pkg;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_READ = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT_RN,
        PATH_END,
        FLUSH,
        DONE
    } state_e;

    localparam logic [1:0] CFG_S0     = 2'd0;
    localparam logic [1:0] CFG_STRIKE = 2'd1;
    localparam logic [1:0] CFG_NPATHS = 2'd2;
    localparam logic [1:0] CFG_NSTEPS = 2'd3;

    localparam logic [15:0] FP16_NAN = 16'h7E00;

endpackage

// File: rtl/mc_cfg_regfile.sv
// Load-indexed 4-word config store: one word per write cycle, index wraps 3->0.
// Writes land on the next edge; the caller gates wr_en so cfg is frozen during a run.
module mc_cfg_regfile
    import mc_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             idx_clr,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] cfg_s0,
    output logic [CNT_W-1:0] cfg_strike,
    output logic [CNT_W-1:0] cfg_npaths,
    output logic [CNT_W-1:0] cfg_nsteps
);

    logic [1:0]       idx;
    logic [CNT_W-1:0] cfg_q [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
        end else if (wr_en) begin
            cfg_q[idx] <= din;
            idx        <= idx + 2'd1;
        end else if (idx_clr) begin
            idx <= '0;
        end
    end

    assign cfg_s0     = cfg_q[CFG_S0];
    assign cfg_strike = cfg_q[CFG_STRIKE];
    assign cfg_npaths = cfg_q[CFG_NPATHS];
    assign cfg_nsteps = cfg_q[CFG_NSTEPS];

endmodule

// File: rtl/mc_sequencer.sv
// Sequences Sobol -> path generator -> pricing over npaths x nsteps, then holds the priced result.
// pg_valid lags sobol_valid by one cycle; every datapath wait is bounded by TIMEOUT and aborts to DONE.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cmd,
    input  logic [CNT_W-1:0]  din,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  cfg_s0,
    output logic [CNT_W-1:0]  cfg_strike,
    output logic [CNT_W-1:0]  cfg_npaths,
    output logic [CNT_W-1:0]  cfg_nsteps,
    output logic              sobol_start,
    input  logic              sobol_valid,
    input  logic [DATA_W-1:0] sobol_data,
    output logic              pg_valid,
    output logic [DATA_W-1:0] pg_data,
    output logic              pg_first,
    output logic              pg_last,
    input  logic              pg_path_done,
    output logic              pr_accum,
    output logic              pr_finish,
    input  logic              pr_valid,
    input  logic [DATA_W-1:0] pr_result
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  step_cnt, path_cnt;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] result;
    logic              cfg_wr, idx_clr, run_start, cfg_zero;
    logic              last_step, last_path;
    logic              wait_state, awaited, tmo_hit;

    mc_cfg_regfile #(.CNT_W(CNT_W)) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (cfg_wr),
        .idx_clr    (idx_clr),
        .din        (din),
        .cfg_s0     (cfg_s0),
        .cfg_strike (cfg_strike),
        .cfg_npaths (cfg_npaths),
        .cfg_nsteps (cfg_nsteps)
    );

    assign cfg_wr    = (cmd == CMD_LOAD) && (state == IDLE || state == LOAD || state == DONE);
    assign idx_clr   = (state == IDLE) && (cmd == CMD_NOP);
    assign run_start = (cmd == CMD_RUN) && (state == IDLE || state == DONE);
    assign cfg_zero  = (cfg_npaths == '0) || (cfg_nsteps == '0);
    // Only consulted once a run is under way, so the zero check has already excluded underflow.
    assign last_step = (step_cnt == cfg_nsteps - CNT_W'(1));
    assign last_path = (path_cnt == cfg_npaths - CNT_W'(1));

    always_comb begin
        wait_state = 1'b0;
        awaited    = 1'b0;
        case (state)
            WAIT_RN:  begin wait_state = 1'b1; awaited = sobol_valid;  end
            PATH_END: begin wait_state = 1'b1; awaited = pg_path_done; end
            FLUSH:    begin wait_state = 1'b1; awaited = pr_valid;     end
            default:  ;
        endcase
    end

    assign tmo_hit = wait_state && !awaited && (timer == TMR_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                case (cmd)
                    CMD_LOAD:           state_nxt = LOAD;
                    CMD_RUN:            state_nxt = cfg_zero ? DONE : REQ;
                    CMD_NOP, CMD_READ:  state_nxt = state;
                    default:            state_nxt = state;
                endcase
            end
            LOAD:     if (cmd != CMD_LOAD) state_nxt = IDLE;
            REQ:      state_nxt = WAIT_RN;
            WAIT_RN: begin
                if (sobol_valid)  state_nxt = last_step ? PATH_END : REQ;
                else if (tmo_hit) state_nxt = DONE;
            end
            PATH_END: begin
                if (pg_path_done) state_nxt = last_path ? FLUSH : REQ;
                else if (tmo_hit) state_nxt = DONE;
            end
            FLUSH:    if (pr_valid || tmo_hit) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sobol_start = (state == REQ);
        busy        = (state == REQ) || (state == WAIT_RN) || (state == PATH_END) || (state == FLUSH);
        done        = (state == DONE);
        pr_accum    = (state == PATH_END) && pg_path_done;
        pr_finish   = pr_accum && last_path;
        dout        = done ? result : DATA_W'(path_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            path_cnt <= '0;
            timer    <= '0;
            result   <= '0;
            err      <= 1'b0;
            pg_valid <= 1'b0;
            pg_data  <= '0;
            pg_first <= 1'b0;
            pg_last  <= 1'b0;
        end else begin
            pg_valid <= 1'b0;
            pg_first <= 1'b0;
            pg_last  <= 1'b0;
            if (state == WAIT_RN && sobol_valid) begin
                pg_valid <= 1'b1;
                pg_data  <= sobol_data;
                pg_first <= (step_cnt == '0);
                pg_last  <= last_step;
                step_cnt <= last_step ? '0 : step_cnt + CNT_W'(1);
            end
            if (pr_accum) path_cnt <= path_cnt + CNT_W'(1);
            if (state == FLUSH && pr_valid) result <= pr_result;
            if (run_start) begin
                err      <= cfg_zero;
                path_cnt <= '0;
                step_cnt <= '0;
                if (cfg_zero) result <= '0;
            end
            if (tmo_hit) begin
                err    <= 1'b1;
                result <= DATA_W'(FP16_NAN);
            end
            if (state_nxt != state) timer <= '0;
            else if (wait_state && !awaited) timer <= timer + TMR_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with a cycle-accurate datapath responder and pulse monitor.
module tb_mc_sequencer;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cmd;
    logic [11:0] din;
    logic [15:0] dout;
    logic        busy, done, err;
    logic [11:0] cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps;
    logic        sobol_start;
    logic        sobol_valid = 1'b0;
    logic [15:0] sobol_data = 16'h0;
    logic        pg_valid;
    logic [15:0] pg_data;
    logic        pg_first, pg_last;
    logic        pg_path_done = 1'b0;
    logic        pr_accum, pr_finish;
    logic        pr_valid = 1'b0;
    logic [15:0] pr_result = 16'h0;

    int errors, checks;
    logic resp_en, spur_sv;
    int sv_dly = 0, pd_dly = 0, pv_dly = 0, sv_num = 0;
    logic pf_seen = 1'b0;
    int start_n = 0, pgv_n = 0, acc_n = 0, fin_n = 0, data_bad = 0;
    logic [63:0] first_mask = '0, last_mask = '0;
    int b_start, b_pgv, b_acc, b_fin, b_bad;

    mc_sequencer #(.CNT_W(12), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .din(din), .dout(dout),
        .busy(busy), .done(done), .err(err),
        .cfg_s0(cfg_s0), .cfg_strike(cfg_strike), .cfg_npaths(cfg_npaths), .cfg_nsteps(cfg_nsteps),
        .sobol_start(sobol_start), .sobol_valid(sobol_valid), .sobol_data(sobol_data),
        .pg_valid(pg_valid), .pg_data(pg_data), .pg_first(pg_first), .pg_last(pg_last),
        .pg_path_done(pg_path_done), .pr_accum(pr_accum), .pr_finish(pr_finish),
        .pr_valid(pr_valid), .pr_result(pr_result)
    );

    always #5 clk = ~clk;

    // Responder drives on the falling edge; the monitor samples 2 time units later.
    always @(negedge clk) begin
        sobol_valid  = spur_sv;
        pg_path_done = 1'b0;
        pr_valid     = 1'b0;
        if (sv_dly > 0) begin
            sv_dly--;
            if (sv_dly == 0) begin
                sv_num++;
                sobol_data  = 16'h1000 + 16'(sv_num);
                sobol_valid = 1'b1;
            end
        end
        if (pd_dly > 0) begin
            pd_dly--;
            if (pd_dly == 0) pg_path_done = 1'b1;
        end
        if (pv_dly > 0) begin
            pv_dly--;
            if (pv_dly == 0) begin
                pr_result = 16'h4500;
                pr_valid  = 1'b1;
            end
        end
        if (resp_en && sobol_start)         sv_dly = 2;
        if (resp_en && pg_valid && pg_last) pd_dly = 1;
        if (resp_en && pf_seen)             pv_dly = 2;
        pf_seen = 1'b0;
        #2;
        if (sobol_start) start_n++;
        if (pg_valid) begin
            if (pg_first) first_mask[pgv_n] = 1'b1;
            if (pg_last)  last_mask[pgv_n]  = 1'b1;
            pgv_n++;
            if (pg_data !== 16'h1000 + 16'(pgv_n)) data_bad++;
        end
        if (pr_accum) acc_n++;
        if (pr_finish) begin
            fin_n++;
            pf_seen = 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [11:0] d);
        cmd = c;
        din = d;
        cyc();
    endtask

    task automatic load4(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
        drive(CMD_LOAD, a); drive(CMD_LOAD, b); drive(CMD_LOAD, c); drive(CMD_LOAD, d);
        drive(CMD_NOP, 12'd0); drive(CMD_NOP, 12'd0);
    endtask

    task automatic snap();
        b_start = start_n; b_pgv = pgv_n; b_acc = acc_n; b_fin = fin_n; b_bad = data_bad;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd = CMD_NOP; din = 12'd0; resp_en = 1'b0; spur_sv = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if ({busy, done, err, sobol_start, pg_valid, pg_first, pg_last, pr_accum, pr_finish} !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0", {busy, done, err, sobol_start, pg_valid, pg_first, pg_last, pr_accum, pr_finish}); end
        checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
        checks++; if ({cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps} !== 48'h0) begin
            errors++; $display("FAIL reset_cfg: got %h want 0", {cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps}); end
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, err}); end
    endtask

    task automatic test_load();
        load4(12'd100, 12'd105, 12'd2, 12'd3);
        checks++; if (cfg_s0 !== 12'd100) begin errors++; $display("FAIL load_s0: got %0d want 100", cfg_s0); end
        checks++; if (cfg_strike !== 12'd105) begin errors++; $display("FAIL load_strike: got %0d want 105", cfg_strike); end
        checks++; if (cfg_npaths !== 12'd2) begin errors++; $display("FAIL load_npaths: got %0d want 2", cfg_npaths); end
        checks++; if (cfg_nsteps !== 12'd3) begin errors++; $display("FAIL load_nsteps: got %0d want 3", cfg_nsteps); end
        // Index survives a non-NOP exit from LOAD, and is cleared only by NOP in IDLE.
        drive(CMD_LOAD, 12'd77); drive(CMD_READ, 12'd0); drive(CMD_LOAD, 12'd55);
        drive(CMD_NOP, 12'd0); drive(CMD_NOP, 12'd0);
        checks++; if ({cfg_s0, cfg_strike} !== {12'd77, 12'd55}) begin
            errors++; $display("FAIL load_idx_retain: got %0d,%0d want 77,55", cfg_s0, cfg_strike); end
        load4(12'd100, 12'd105, 12'd2, 12'd3);
        checks++; if ({cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps} !== {12'd100, 12'd105, 12'd2, 12'd3}) begin
            errors++; $display("FAIL load_idx_clear: got %h want 064069002003", {cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps}); end
    endtask

    task automatic test_run_main();
        int n;
        snap();
        resp_en = 1'b1;
        drive(CMD_RUN, 12'd0);
        checks++; if ({busy, sobol_start} !== 2'b11) begin errors++; $display("FAIL run_first_req: got %b want 11", {busy, sobol_start}); end
        drive(CMD_LOAD, 12'd999); drive(CMD_LOAD, 12'd999);
        cmd = CMD_NOP;
        wait_done(n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done: got %b want 1 after %0d cycles", done, n); end
        checks++; if (dout !== 16'h4500) begin errors++; $display("FAIL run_dout: got %h want 4500", dout); end
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL run_busy_err: got %b want 00", {busy, err}); end
        checks++; if (start_n - b_start !== 6) begin errors++; $display("FAIL run_starts: got %0d want 6", start_n - b_start); end
        checks++; if (pgv_n - b_pgv !== 6) begin errors++; $display("FAIL run_pg_valid: got %0d want 6", pgv_n - b_pgv); end
        checks++; if (16'(first_mask >> b_pgv) !== 16'h0009) begin errors++; $display("FAIL run_pg_first: got %h want 0009", 16'(first_mask >> b_pgv)); end
        checks++; if (16'(last_mask >> b_pgv) !== 16'h0024) begin errors++; $display("FAIL run_pg_last: got %h want 0024", 16'(last_mask >> b_pgv)); end
        checks++; if (acc_n - b_acc !== 2) begin errors++; $display("FAIL run_accum: got %0d want 2", acc_n - b_acc); end
        checks++; if (fin_n - b_fin !== 1) begin errors++; $display("FAIL run_finish: got %0d want 1", fin_n - b_fin); end
        checks++; if (data_bad - b_bad !== 0) begin errors++; $display("FAIL run_pg_data: got %0d bad samples want 0", data_bad - b_bad); end
        checks++; if ({cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps} !== {12'd100, 12'd105, 12'd2, 12'd3}) begin
            errors++; $display("FAIL run_cfg_frozen: got %h want 064069002003", {cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps}); end
    endtask

    task automatic test_single_step();
        int n;
        load4(12'd100, 12'd105, 12'd1, 12'd1);
        snap();
        drive(CMD_RUN, 12'd0);
        cmd = CMD_NOP;
        wait_done(n);
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL single_done_err: got %b want 10", {done, err}); end
        checks++; if (pgv_n - b_pgv !== 1) begin errors++; $display("FAIL single_pg_valid: got %0d want 1", pgv_n - b_pgv); end
        checks++; if ({16'(first_mask >> b_pgv), 16'(last_mask >> b_pgv)} !== {16'h0001, 16'h0001}) begin
            errors++; $display("FAIL single_first_last: got %h/%h want 0001/0001", 16'(first_mask >> b_pgv), 16'(last_mask >> b_pgv)); end
        checks++; if ({acc_n - b_acc, fin_n - b_fin} !== {32'd1, 32'd1}) begin
            errors++; $display("FAIL single_accum_finish: got %0d/%0d want 1/1", acc_n - b_acc, fin_n - b_fin); end
        checks++; if (dout !== 16'h4500) begin errors++; $display("FAIL single_dout: got %h want 4500", dout); end
    endtask

    task automatic test_zero_count();
        load4(12'd100, 12'd105, 12'd0, 12'd3);
        snap();
        drive(CMD_RUN, 12'd0);
        cmd = CMD_NOP;
        checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL zero_flags: got %b want 110", {done, err, busy}); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL zero_dout: got %h want 0000", dout); end
        cyc(); cyc(); cyc();
        checks++; if (start_n - b_start !== 0) begin errors++; $display("FAIL zero_no_start: got %0d want 0", start_n - b_start); end
    endtask

    task automatic test_timeout();
        int n;
        load4(12'd100, 12'd105, 12'd1, 12'd1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        snap();
        resp_en = 1'b0;
        drive(CMD_RUN, 12'd0);
        cmd = CMD_NOP;
        checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL tmo_run_clears_err: got %b want 10", {busy, err}); end
        repeat (8) cyc();
        checks++; if ({busy, done, err} !== 3'b100) begin errors++; $display("FAIL tmo_not_early: got %b want 100", {busy, done, err}); end
        wait_done(n);
        checks++; if (n < 1 || n > 3) begin errors++; $display("FAIL tmo_latency: got %0d extra cycles want 1..3", n); end
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL tmo_flags: got %b want 11", {done, err}); end
        checks++; if (dout !== 16'h7E00) begin errors++; $display("FAIL tmo_dout: got %h want 7e00", dout); end
        checks++; if (start_n - b_start !== 1) begin errors++; $display("FAIL tmo_starts: got %0d want 1", start_n - b_start); end
        resp_en = 1'b1;
        drive(CMD_RUN, 12'd0);
        cmd = CMD_NOP;
        checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL rerun_clears_err: got %b want 10", {busy, err}); end
        wait_done(n);
        checks++; if ({done, err, dout} !== {2'b10, 16'h4500}) begin
            errors++; $display("FAIL rerun_result: got %b/%b/%h want 1/0/4500", done, err, dout); end
    endtask

    task automatic test_reset_mid_run();
        resp_en = 1'b0;
        drive(CMD_RUN, 12'd0);
        cmd = CMD_NOP;
        cyc(); cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, err, sobol_start, pg_valid, pr_accum, pr_finish, dout} !== 23'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got %b/%b/%b dout %h want 0", busy, done, err, dout); end
        checks++; if ({cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps} !== 48'h0) begin
            errors++; $display("FAIL mid_reset_cfg: got %h want 0", {cfg_s0, cfg_strike, cfg_npaths, cfg_nsteps}); end
        cyc();
        rst = 1'b0;
        cyc();
        snap();
        spur_sv = 1'b1;
        cyc();
        spur_sv = 1'b0;
        cyc();
        checks++; if (pg_valid !== 1'b0) begin errors++; $display("FAIL spurious_pg_valid: got %b want 0", pg_valid); end
        cyc();
        checks++; if ({pgv_n - b_pgv, busy, done} !== {32'd0, 2'b00}) begin
            errors++; $display("FAIL spurious_idle: pulses %0d busy %b done %b want 0/0/0", pgv_n - b_pgv, busy, done); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load();
        test_run_main();
        test_single_step();
        test_zero_count();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
